fir_filter: RTL and testbench

- Direct-form, fully parallel FIR filter. It sits directly downstream of the memory-backed signal generator and consumes its sample stream, one sample per clock when i_valid is held high.
- Coefficients are runtime-programmable through a simple write port.
- Fixed 3-cycle pipeline: delay line, product register, sum with round/saturate register.
- Drives the filtered stream to the next stage (DAC model or checker).

---
 rtl/fir_pkg.sv | 38 +++
 rtl/fir_round_sat.sv | 42 ++++
 rtl/fir_filter.sv | 112 +++++++++++
 tb/tb_fir_filter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, types and helpers for the FIR filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

    // Default widths; the Q-format fraction gives Q1.15 coefficients.
    localparam int NB_DATA_DEF  = 16;
    localparam int NB_COEF_DEF  = 16;
    localparam int NBF_COEF_DEF = 15;
    localparam int N_TAPS_DEF   = 8;
    localparam int NB_OUT_DEF   = 16;

    typedef logic signed [NB_DATA_DEF-1:0] sample_t;
    typedef logic signed [NB_COEF_DEF-1:0] coef_t;

    // Number of bits needed to index v entries (v >= 2).
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Half-LSB of the output grid, added before truncating the fraction.
    function automatic longint round_ofs(input int nbf);
        return longint'(1) << (nbf - 1);
    endfunction

    // Largest positive coefficient: "1.0" minus one LSB.
    function automatic longint pass_coef(input int nbf);
        return (longint'(1) << nbf) - 1;
    endfunction

    localparam longint ROUND_OFS = round_ofs(NBF_COEF_DEF);
    localparam coef_t  COEF_PASS = coef_t'(pass_coef(NBF_COEF_DEF));

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, drop the coefficient fraction, then saturate or wrap to NB_OUT.
// Latency: combinational.
// Backpressure: none.
// Ports: acc_i (full-precision signed sum), out_o (signed NB_OUT result).
// FIR_SAT_EN defined -> clamp to the NB_OUT signed range; undefined -> keep low bits.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int NB_ACC = 35,
    parameter int NBF    = NBF_COEF_DEF,
    parameter int NB_OUT = NB_OUT_DEF
) (
    input  logic signed [NB_ACC-1:0] acc_i,
    output logic signed [NB_OUT-1:0] out_o
);

    localparam logic signed [NB_ACC-1:0] RND = NB_ACC'(round_ofs(NBF));

    logic signed [NB_ACC-1:0] rounded;

    assign rounded = (acc_i + RND) >>> NBF;

`ifdef FIR_SAT_EN
    localparam logic signed [NB_ACC-1:0] MAX_V = NB_ACC'((longint'(1) << (NB_OUT - 1)) - 1);
    localparam logic signed [NB_ACC-1:0] MIN_V = NB_ACC'(-(longint'(1) << (NB_OUT - 1)));

    always_comb begin
        out_o = rounded[NB_OUT-1:0];
        if (rounded > MAX_V) begin
            out_o = MAX_V[NB_OUT-1:0];
        end else if (rounded < MIN_V) begin
            out_o = MIN_V[NB_OUT-1:0];
        end
    end
`else
    // Upper bits are intentionally discarded in wrap mode.
    logic unused_hi;
    assign unused_hi = ^rounded[NB_ACC-1:NB_OUT];
    assign out_o     = rounded[NB_OUT-1:0];
`endif

endmodule

// File: rtl/fir_filter.sv
// Direct-form fully parallel FIR with runtime-programmable coefficients.
// Latency: 3 cycles, sample in T -> o_valid in T+3 (delay line, products, sum).
// Backpressure: none; one sample per clock, bubbles hold the delay line.
// Ports: i_clock/i_reset (async, active-high); i_valid/i_data sample in;
//        i_coef_we/i_coef_addr/i_coef_data coefficient write; o_valid/o_data out.
// Optional: FIR_SAT_EN (saturating output, handled in fir_round_sat).
module fir_filter
    import fir_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int NB_COEF  = NB_COEF_DEF,
    parameter int NBF_COEF = NBF_COEF_DEF,
    parameter int N_TAPS   = N_TAPS_DEF,
    parameter int NB_OUT   = NB_OUT_DEF
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic signed [NB_DATA-1:0]   i_data,
    input  logic                        i_coef_we,
    input  logic [clog2(N_TAPS)-1:0]    i_coef_addr,
    input  logic signed [NB_COEF-1:0]   i_coef_data,
    output logic                        o_valid,
    output logic signed [NB_OUT-1:0]    o_data
);

    localparam int NB_ADDR = clog2(N_TAPS);
    localparam int NB_PROD = NB_DATA + NB_COEF;
    localparam int NB_ACC  = NB_PROD + clog2(N_TAPS);
    localparam logic signed [NB_COEF-1:0] H_PASS = NB_COEF'(pass_coef(NBF_COEF));

    logic signed [NB_DATA-1:0] x_q [N_TAPS];
    logic signed [NB_DATA-1:0] x_d [N_TAPS];
    logic signed [NB_COEF-1:0] h_q [N_TAPS];
    logic signed [NB_COEF-1:0] h_d [N_TAPS];
    logic signed [NB_PROD-1:0] p_q [N_TAPS];
    logic signed [NB_PROD-1:0] p_d [N_TAPS];
    logic [2:0]                vld_q, vld_d;
    logic signed [NB_OUT-1:0]  o_data_q, o_data_d;
    logic signed [NB_ACC-1:0]  acc;
    logic signed [NB_OUT-1:0]  rnd_out;

    // Delay line advances only on a real sample.
    always_comb begin
        x_d = x_q;
        if (i_valid) begin
            x_d[0] = i_data;
            for (int k = 1; k < N_TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    // Compare against every tap index so out-of-range addresses match nothing.
    always_comb begin
        h_d = h_q;
        for (int k = 0; k < N_TAPS; k++) begin
            if (i_coef_we && (i_coef_addr == NB_ADDR'(k))) begin
                h_d[k] = i_coef_data;
            end
        end
    end

    // Products use h_q one cycle after the sample, so a write in the sample's
    // own cycle already applies to it.
    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            p_d[k] = NB_PROD'(x_q[k]) * NB_PROD'(h_q[k]);
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            acc = acc + NB_ACC'(p_q[k]);
        end
    end

    fir_round_sat #(
        .NB_ACC (NB_ACC),
        .NBF    (NBF_COEF),
        .NB_OUT (NB_OUT)
    ) u_round_sat (
        .acc_i  (acc),
        .out_o  (rnd_out)
    );

    assign vld_d    = {vld_q[1:0], i_valid};
    assign o_data_d = vld_q[1] ? rnd_out : o_data_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x_q[k] <= '0;
                p_q[k] <= '0;
                h_q[k] <= (k == 0) ? H_PASS : '0;
            end
            vld_q    <= '0;
            o_data_q <= '0;
        end else begin
            x_q      <= x_d;
            h_q      <= h_d;
            p_q      <= p_d;
            vld_q    <= vld_d;
            o_data_q <= o_data_d;
        end
    end

    assign o_valid = vld_q[2];
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: drivers push expected results, monitors pop on o_valid.
// Latency: checks every output lands exactly 3 cycles after its sample.
// Backpressure: none in the DUT; the bench streams freely.
module tb_fir_filter;
    import fir_pkg::*;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               i_valid = 1'b0;
    logic signed [15:0] i_data = '0;
    logic               coef_we = 1'b0;
    logic [2:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               o_valid;
    logic signed [15:0] o_data;

    logic               v6 = 1'b0;
    logic               we6 = 1'b0;
    logic               o_valid6;
    logic signed [15:0] o_data6;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    exp_t exp6_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_filter u_dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_coef_we   (coef_we),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .o_valid     (o_valid),
        .o_data      (o_data)
    );

    fir_filter #(.N_TAPS(6)) u_dut6 (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_valid     (v6),
        .i_data      (i_data),
        .i_coef_we   (we6),
        .i_coef_addr (coef_addr),
        .i_coef_data (coef_data),
        .o_valid     (o_valid6),
        .o_data      (o_data6)
    );

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected o_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("o_data", int'(o_data), e.val);
                check("latency cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (o_valid6) begin
            if (exp6_q.size() == 0) begin
                check("unexpected o_valid (6 taps)", 1, 0);
            end else begin
                exp_t e;
                e = exp6_q.pop_front();
                check("o_data (6 taps)", int'(o_data6), e.val);
                check("latency cycle (6 taps)", cyc, e.cyc);
            end
        end
    end

    // All drivers run from just after a rising edge.
    task automatic do_reset();
        i_valid = 1'b0;
        coef_we = 1'b0;
        v6      = 1'b0;
        we6     = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int d, input int e);
        exp_t x;
        x.val = e;
        x.cyc = cyc + 3;
        exp_q.push_back(x);
        i_valid = 1'b1;
        i_data  = 16'(d);
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic send6(input int d, input int e);
        exp_t x;
        x.val = e;
        x.cyc = cyc + 3;
        exp6_q.push_back(x);
        v6     = 1'b1;
        i_data = 16'(d);
        @(posedge clk);
        #1 v6 = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 16'(val);
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    // Wait (bounded) for all expected outputs, then linger to catch stray pulses.
    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() + exp6_q.size()) != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        check({name, " outstanding results"}, exp_q.size() + exp6_q.size(), 0);
        exp_q.delete();
        exp6_q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

`ifdef FIR_SAT_EN
    int ovf_exp [8] = '{32766, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
`else
    int ovf_exp [8] = '{32766, -4, 32762, -8, 32758, -12, 32754, -16};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        // Reset state.
        #1 rst = 1'b1;
        #2;
        check("reset o_valid", int'(o_valid), 0);
        check("reset o_data", int'(o_data), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Passthrough coefficients after reset.
        send(1000, 1000);
        drain("passthrough 1000");
        send(-32768, -32767);
        drain("passthrough -32768");

        // Impulse response with a programmed ramp.
        do_reset();
        for (int k = 0; k < 8; k++) wr_coef(k, 16'h0800 * (k + 1));
        send(16384, 1024);
        for (int k = 1; k < 8; k++) send(0, 1024 * (k + 1));
        send(0, 0);
        drain("impulse");

        // Full-scale accumulation: saturate or wrap.
        do_reset();
        for (int k = 0; k < 8; k++) wr_coef(k, 32767);
        for (int k = 0; k < 8; k++) send(32767, ovf_exp[k]);
        drain("overflow");

        // Bubble: the delay line must not advance on the idle cycle.
        do_reset();
        send(100, 100);
        i_data = 16'(12345);
        @(posedge clk);
        #1;
        send(200, 200);
        drain("bubble");

        // Coefficient write in the same cycle as the sample.
        do_reset();
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'sh4000;
        send(2000, 1000);
        coef_we = 1'b0;
        drain("coef write same cycle");

        // Out-of-range tap addresses on a 6-tap instance change nothing.
        do_reset();
        we6       = 1'b1;
        coef_addr = 3'd7;
        coef_data = 16'sh4000;
        send6(1000, 1000);
        coef_addr = 3'd6;
        send6(1000, 1000);
        we6 = 1'b0;
        drain("out-of-range write");

        // Mid-stream reset discards in-flight samples and coefficients.
        do_reset();
        wr_coef(0, 16'sh4000);
        send(1000, 500);
        send(1000, 500);
        send(1000, 500);
        @(negedge clk);
        #1;
        check("o_valid before mid-stream reset", int'(o_valid), 1);
        rst = 1'b1;
        #1;
        check("mid-stream reset o_valid", int'(o_valid), 0);
        check("mid-stream reset o_data", int'(o_data), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(1000, 1000);
        drain("after mid-stream reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
